// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that shares one synchronous FIFO
// write port among N_REQ valid/ready/last producers. It grants one producer
// for a burst of at most MAX_BURST beats, pauses while the FIFO reports
// almost-full, and registers the write strobe and data into the FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; pick the next valid requester starting at ptr_q
// ST_BURST | requester gid_q owns the write port until last/cap/stall

module fifo_write_arbiter #(
   parameter int WIDTH     = 8,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4,
   parameter int ID_W      = $clog2(N_REQ)
) (
   input  logic                   i_CLK,
   input  logic                   i_RESET,
   input  logic [N_REQ-1:0]       i_VALID,
   input  logic [N_REQ-1:0]       i_LAST,
   input  logic [N_REQ*WIDTH-1:0] i_DATA,
   output logic [N_REQ-1:0]       o_READY,
   input  logic                   i_FIFO_ALMOST_FULL,
   input  logic                   i_FIFO_FULL,
   output logic                   o_FIFO_WR_EN,
   output logic [WIDTH-1:0]       o_FIFO_WR_DATA,
   output logic [N_REQ-1:0]       o_GRANT,
   output logic [ID_W-1:0]        o_GRANT_ID,
   output logic                   o_BUSY,
   output logic                   o_DROP
);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   gid_q, gid_d;
   logic [7:0]        bcnt_q, bcnt_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic              wr_en_q;
   logic [WIDTH-1:0]  wr_data_q;
   logic              drop_q;

   logic              sel_found;
   logic [ID_W-1:0]   sel_id;
   logic [ID_W-1:0]   rr_idx;
   logic [ID_W-1:0]   next_id;
   logic              g_valid;
   logic              g_last;
   logic              accept;
   logic              cap_hit;

   assign g_valid = i_VALID[gid_q];
   assign g_last  = i_LAST[gid_q];
   assign accept  = (state_q == ST_BURST) && g_valid && !i_FIFO_ALMOST_FULL;
   assign cap_hit = (bcnt_q + 8'd1) == 8'(MAX_BURST);
   assign next_id = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;

   // Round-robin search: first valid requester at or after ptr_q, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = ptr_q;
      rr_idx    = ptr_q;
      for (int i = 0; i < N_REQ; i++) begin
         rr_idx = ID_W'((int'(ptr_q) + i) % N_REQ);
         if (!sel_found && i_VALID[rr_idx]) begin
            sel_found = 1'b1;
            sel_id    = rr_idx;
         end
      end
   end

   // State register and arbitration bookkeeping.
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         bcnt_q  <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         bcnt_q  <= bcnt_d;
         grant_q <= grant_d;
      end
   end

   // Next-state logic; almost-full suppresses both new grants and the stall exit.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      bcnt_d  = bcnt_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_found && !i_FIFO_ALMOST_FULL) begin
               state_d = ST_BURST;
               gid_d   = sel_id;
               bcnt_d  = '0;
               grant_d = N_REQ'(1) << sel_id;
            end
         end
         ST_BURST: begin
            if (accept) begin
               bcnt_d = bcnt_q + 8'd1;
               if (g_last || cap_hit) begin
                  state_d = ST_IDLE;
                  ptr_d   = next_id;
                  grant_d = '0;
               end
            end else if (!g_valid && !i_FIFO_ALMOST_FULL) begin
               state_d = ST_IDLE;
               ptr_d   = next_id;
               grant_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Ready goes only to the granted requester, and only when the FIFO has room.
   always_comb begin
      o_READY = '0;
      if (state_q == ST_BURST && g_valid && !i_FIFO_ALMOST_FULL) begin
         o_READY[gid_q] = 1'b1;
      end
   end

   // Registered write path; reset squashes any in-flight write.
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         wr_en_q <= accept;
         if (accept) begin
            wr_data_q <= i_DATA[gid_q*WIDTH +: WIDTH];
         end
         drop_q <= i_FIFO_FULL && wr_en_q;
      end
   end

   assign o_FIFO_WR_EN   = wr_en_q;
   assign o_FIFO_WR_DATA = wr_data_q;
   assign o_GRANT        = grant_q;
   assign o_GRANT_ID     = gid_q;
   assign o_BUSY         = (state_q == ST_BURST);
   assign o_DROP         = drop_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: producer queues drive the requesters, the
// expected FIFO write order is queued up front and checked as writes appear.
// Two instances (MAX_BURST=4 and MAX_BURST=2) share the stimulus; sel picks
// which one is being checked.

module tb_fifo_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  valid, last;
   logic [31:0] data;
   logic        af, full;

   logic [3:0] ready4, grant4, ready2, grant2;
   logic [1:0] gid4, gid2;
   logic [7:0] wdata4, wdata2;
   logic       wen4, busy4, drop4, wen2, busy2, drop2;

   logic [3:0] ready_s, grant_s;
   logic [1:0] gid_s;
   logic [7:0] wdata_s;
   logic       wen_s, busy_s, drop_s;
   logic       sel;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic [8:0] src[4][$];
   logic [3:0] glog[$];
   logic [3:0] prev_grant;
   logic       last_wr;

   always #5 clk = ~clk;

   fifo_write_arbiter #(.WIDTH(8), .N_REQ(4), .MAX_BURST(4)) dut4 (
      .i_CLK(clk), .i_RESET(rst), .i_VALID(valid), .i_LAST(last), .i_DATA(data),
      .o_READY(ready4), .i_FIFO_ALMOST_FULL(af), .i_FIFO_FULL(full),
      .o_FIFO_WR_EN(wen4), .o_FIFO_WR_DATA(wdata4), .o_GRANT(grant4),
      .o_GRANT_ID(gid4), .o_BUSY(busy4), .o_DROP(drop4));

   fifo_write_arbiter #(.WIDTH(8), .N_REQ(4), .MAX_BURST(2)) dut2 (
      .i_CLK(clk), .i_RESET(rst), .i_VALID(valid), .i_LAST(last), .i_DATA(data),
      .o_READY(ready2), .i_FIFO_ALMOST_FULL(af), .i_FIFO_FULL(full),
      .o_FIFO_WR_EN(wen2), .o_FIFO_WR_DATA(wdata2), .o_GRANT(grant2),
      .o_GRANT_ID(gid2), .o_BUSY(busy2), .o_DROP(drop2));

   always_comb begin
      ready_s = sel ? ready2 : ready4;
      grant_s = sel ? grant2 : grant4;
      gid_s   = sel ? gid2   : gid4;
      wdata_s = sel ? wdata2 : wdata4;
      wen_s   = sel ? wen2   : wen4;
      busy_s  = sel ? busy2  : busy4;
      drop_s  = sel ? drop2  : drop4;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < 4; k++) begin
         if (src[k].size() > 0) begin
            valid[k]        = 1'b1;
            data[k*8 +: 8]  = src[k][0][7:0];
            last[k]         = src[k][0][8];
         end else begin
            valid[k]        = 1'b0;
            data[k*8 +: 8]  = 8'h00;
            last[k]         = 1'b0;
         end
      end
   endtask

   // One clock: note handshakes before the edge, advance producers after it,
   // then check writes against the expected order and o_DROP against FULL.
   task automatic cyc();
      logic [3:0] acc;
      logic       full_b, rst_b;
      logic [7:0] e;
      #1;
      acc    = valid & ready_s;
      full_b = full;
      rst_b  = rst;
      chk("ready_onehot", ($countones(ready_s) <= 1), 1);
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (acc[k]) void'(src[k].pop_front());
      end
      drive();
      #1;
      if (wen_s) begin
         chk("write_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_data", wdata_s, e);
         end
      end
      chk("drop", drop_s, (last_wr && full_b && !rst_b));
      if (grant_s != 4'b0000 && grant_s != prev_grant) glog.push_back(grant_s);
      prev_grant = grant_s;
      last_wr    = wen_s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) src[k].delete();
      exp_q.delete();
      glog.delete();
      drive();
      cyc();
      cyc();
      chk("rst_wr_en", wen_s, 0);
      chk("rst_wr_data", wdata_s, 0);
      chk("rst_grant", grant_s, 0);
      chk("rst_grant_id", gid_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_ready", ready_s, 0);
      chk("rst_drop", drop_s, 0);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] eg[5];
      rst = 1'b1; valid = '0; last = '0; data = '0; af = 1'b0; full = 1'b0;
      sel = 1'b0; prev_grant = '0; last_wr = 1'b0;

      // single requester, four beats with last on the fourth
      do_reset();
      for (int i = 0; i < 4; i++) begin
         src[0].push_back({(i == 3), 8'(8'h10 + i)});
         exp_q.push_back(8'(8'h10 + i));
      end
      drive();
      cyc();
      chk("t1_grant", grant_s, 4'b0001);
      chk("t1_busy", busy_s, 1);
      chk("t1_gid", gid_s, 0);
      chk("t1_ready", ready_s, 4'b0001);
      repeat (4) cyc();
      chk("t1_idle_busy", busy_s, 0);
      chk("t1_idle_grant", grant_s, 0);
      cyc();
      chk("t1_wr_off", wen_s, 0);
      chk("t1_drained", exp_q.size(), 0);

      // pointer now 1: requester 1 wins over 0; FIFO full makes o_DROP pulse
      glog.delete();
      full = 1'b1;
      src[0].push_back({1'b1, 8'h20});
      src[1].push_back({1'b1, 8'h21});
      exp_q.push_back(8'h21);
      exp_q.push_back(8'h20);
      drive();
      repeat (8) cyc();
      full = 1'b0;
      chk("ptr_drained", exp_q.size(), 0);
      chk("ptr_grants", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("ptr_first", glog[0], 4'b0010);
         chk("ptr_second", glog[1], 4'b0001);
      end

      // round-robin fairness with MAX_BURST=2
      sel = 1'b1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < ((k == 0) ? 4 : 2); b++) begin
            src[k].push_back({1'b0, 8'(k*16 + b)});
         end
      end
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(8'(k*16));
         exp_q.push_back(8'(k*16 + 1));
      end
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      drive();
      cyc();
      chk("rr_grant0", grant_s, 4'b0001);
      cyc();
      cyc();
      chk("rr_gap", grant_s, 0);
      cyc();
      chk("rr_grant1", grant_s, 4'b0010);
      repeat (20) cyc();
      chk("rr_drained", exp_q.size(), 0);
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      chk("rr_grants", glog.size(), 5);
      if (glog.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("rr_order", glog[i], eg[i]);
      end

      // burst cap: requester 2 streams 10 beats, MAX_BURST=4
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         src[2].push_back({1'b0, 8'(8'h40 + i)});
         exp_q.push_back(8'(8'h40 + i));
      end
      drive();
      repeat (22) cyc();
      chk("cap_drained", exp_q.size(), 0);
      chk("cap_grants", glog.size(), 3);
      for (int i = 0; i < glog.size(); i++) chk("cap_grant", glog[i], 4'b0100);

      // backpressure after beat 2
      do_reset();
      for (int i = 0; i < 4; i++) begin
         src[0].push_back({(i == 3), 8'(8'h50 + i)});
         exp_q.push_back(8'(8'h50 + i));
      end
      drive();
      repeat (3) cyc();
      af = 1'b1;
      repeat (5) begin
         cyc();
         chk("bp_ready", ready_s, 0);
         chk("bp_grant", grant_s, 4'b0001);
         chk("bp_wr_en", wen_s, 0);
      end
      af = 1'b0;
      cyc();
      chk("bp_resume_busy", busy_s, 1);
      cyc();
      chk("bp_done_busy", busy_s, 0);
      cyc();
      chk("bp_drained", exp_q.size(), 0);

      // producer stall after one beat
      do_reset();
      src[0].push_back({1'b0, 8'h60});
      src[1].push_back({1'b0, 8'h61});
      src[1].push_back({1'b1, 8'h62});
      exp_q.push_back(8'h60);
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h62);
      drive();
      cyc();
      chk("st_grant0", grant_s, 4'b0001);
      cyc();
      cyc();
      chk("st_exit", grant_s, 0);
      cyc();
      chk("st_grant1", grant_s, 4'b0010);
      repeat (5) cyc();
      chk("st_drained", exp_q.size(), 0);

      // reset mid-burst: pointer was moved to 2 first, reset must put it back to 0
      do_reset();
      src[1].push_back({1'b1, 8'h80});
      exp_q.push_back(8'h80);
      drive();
      repeat (4) cyc();
      for (int i = 0; i < 4; i++) src[2].push_back({(i == 3), 8'(8'h70 + i)});
      exp_q.push_back(8'h70);
      drive();
      cyc();
      chk("mr_grant", grant_s, 4'b0100);
      cyc();
      rst = 1'b1;
      cyc();
      chk("mr_wr_en", wen_s, 0);
      chk("mr_wr_data", wdata_s, 0);
      chk("mr_grant0", grant_s, 0);
      chk("mr_gid", gid_s, 0);
      chk("mr_busy", busy_s, 0);
      chk("mr_ready", ready_s, 0);
      chk("mr_drop", drop_s, 0);
      rst = 1'b0;
      src[0].push_back({1'b1, 8'h90});
      exp_q.push_back(8'h90);
      exp_q.push_back(8'h72);
      exp_q.push_back(8'h73);
      drive();
      repeat (12) cyc();
      chk("mr_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port among N_REQ producers. Each producer uses a valid/ready/last handshake. The arbiter grants one producer at a time for a bounded burst, throttles on the FIFO's almost-full flag, and drives a registered write strobe and data into the FIFO. It sits directly in front of the team's SYNC FIFO write port, in place of ad-hoc write muxing.

## Interface
Parameters:
- WIDTH, 8, data width; equals the FIFO WIDTH.
- N_REQ, 4, number of requesters; range 2..16.
- MAX_BURST, 4, maximum beats per grant; range 1..255.
- ID_W, $clog2(N_REQ), width of the granted-index output.

Ports (clock and reset first):
- i_CLK, in, 1, single clock. All logic is on the rising edge.
- i_RESET, in, 1, synchronous, active-high reset.
- i_VALID, in, N_REQ, per-requester data valid.
- i_LAST, in, N_REQ, per-requester end-of-packet marker; sampled only on an accepted beat.
- i_DATA, in, N_REQ*WIDTH, packed requester data; requester k occupies bits [k*WIDTH +: WIDTH].
- o_READY, out, N_REQ, per-requester ready; at most one bit high.
- i_FIFO_ALMOST_FULL, in, 1, from the FIFO's almost-full output.
- i_FIFO_FULL, in, 1, from the FIFO's full output.
- o_FIFO_WR_EN, out, 1, registered FIFO write enable.
- o_FIFO_WR_DATA, out, WIDTH, registered FIFO write data.
- o_GRANT, out, N_REQ, one-hot current grant; all zero when in IDLE.
- o_GRANT_ID, out, ID_W, index of the current or last grant.
- o_BUSY, out, 1, high while in BURST.
- o_DROP, out, 1, one-cycle pulse if i_FIFO_FULL is high while o_FIFO_WR_EN is high (overflow sticky for debug is external).

## Operation
- States: IDLE and BURST. There is a round-robin pointer PTR (ID_W bits) and a beat counter BCNT (8 bits).
- IDLE:
  - If any i_VALID bit is high and i_FIFO_ALMOST_FULL=0, select the first k with i_VALID[k]=1, searching PTR, PTR+1, … modulo N_REQ.
  - Load o_GRANT, o_GRANT_ID and BCNT=0, then go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - o_READY[g] = i_VALID[g] & ~i_FIFO_ALMOST_FULL, where g is the granted index.
  - A beat is accepted when i_VALID[g] & o_READY[g]. On an accepted beat, BCNT increments.
  - Leave to IDLE, with PTR <= g+1 (mod N_REQ) and o_GRANT cleared, on any of the following:
    - an accepted beat with i_LAST[g]=1;
    - an accepted beat that makes BCNT == MAX_BURST;
    - i_VALID[g]=0 while i_FIFO_ALMOST_FULL=0 (producer stalled).
  - While i_FIFO_ALMOST_FULL=1, hold the grant, keep o_READY low, and do not advance BCNT.
- Write path: o_FIFO_WR_EN <= accepted beat, and o_FIFO_WR_DATA <= i_DATA[g] (loaded only on an accepted beat, held otherwise).
- Non-granted requesters always see o_READY=0, regardless of their i_VALID.
- PTR wrap: g = N_REQ-1 gives PTR=0.
- Integration rule: the FIFO's p_ALMOST_FULL must be ≤ DEPTH-3. This absorbs the registered flag plus the registered write. o_DROP must never fire in a correct integration.

## Timing
- Reset values: state=IDLE, PTR=0, BCNT=0, o_READY=0, o_GRANT=0, o_GRANT_ID=0, o_BUSY=0, o_FIFO_WR_EN=0, o_FIFO_WR_DATA=0, o_DROP=0.
- Reset mid-burst returns to IDLE on the next edge. Any in-flight registered write is squashed (o_FIFO_WR_EN=0).
- Arbitration latency is 1 cycle: valid is seen in IDLE at edge n, BURST begins at n+1, and the earliest accept is in cycle n+1.
- Write latency is 1 cycle: a beat accepted in cycle n appears as o_FIFO_WR_EN=1 in cycle n+1.
- Throughput: at most MAX_BURST beats per MAX_BURST+1 cycles per grant. Each re-arbitration costs one IDLE cycle.
- o_READY is combinational from state, i_VALID[g] and i_FIFO_ALMOST_FULL. Every other output is registered.
- Simultaneous cases:
  - i_LAST and BCNT reaching MAX_BURST on the same beat cause a single exit.
  - i_FIFO_ALMOST_FULL rising in the same cycle as an otherwise-exiting valid drop keeps the grant (the almost-full hold wins).

## Test plan
- Single requester: reset, then i_VALID=4'b0001 with data 0x10..0x13 and i_LAST on the 4th beat. Expect grant in cycle 1, o_FIFO_WR_EN high in cycles 2-5 with 0x10..0x13, then IDLE and PTR=1.
- Round-robin fairness: all four requesters hold valid continuously with MAX_BURST=2. Expect the grant order 0,1,2,3,0, two writes each, with one IDLE cycle between grants.
- Burst cap: requester 2 streams 10 beats with no i_LAST and MAX_BURST=4. Expect it to be regranted after the other idle requesters are skipped: 4+4+2 beats, and the data order is preserved.
- Backpressure: raise i_FIFO_ALMOST_FULL mid-burst after beat 2 for 5 cycles. Expect o_READY=0, no writes, grant held, BCNT=2; the burst then resumes and completes with the correct data.
- Producer stall: the granted requester drops valid after 1 beat. Expect exit to IDLE and the grant to pass to the next valid requester.
- Reset mid-burst: assert i_RESET during beat 2. Expect every output at its reset value on the next cycle, then normal arbitration starting from PTR=0.
